// File: rtl/load_store_unit.sv
// Memory-access stage: word-indexed loads, read-modify-write sub-word stores.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
   parameter int MEM_WORDS = 4,
   parameter int RD_LAT    = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic        memRead,
   output logic        memWrite,
   output logic [31:0] memAddress,
   output logic [31:0] memDataIn,
   input  logic [31:0] memDataOut
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RD   = 2'd1;
   localparam logic [1:0] WR   = 2'd2;
   localparam logic [1:0] RESP = 2'd3;

   localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(RD_LAT - 1);

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic          wr_q;
   logic          sgn_q;
   logic [1:0]    size_q;
   logic [1:0]    off_q;
   logic [15:0]   wdata_q;

   logic          accept;
   logic          in_byte;
   logic          in_half;
   logic          in_word;
   logic [1:0]    off_in;
   logic [31:0]   idx_in;
   logic [4:0]    sh;
   logic [31:0]   mask;
   logic [31:0]   ins;
   logic [31:0]   merged;
   logic [7:0]    lb;
   logic [15:0]   lh;
   logic [31:0]   loaded;

   assign req_ready  = (state == IDLE) & ~reset;
   assign memRead    = (state == RD);
   assign memWrite   = (state == WR);
   assign resp_valid = (state == RESP);
   assign accept     = req_valid & req_ready;

   assign in_byte = (req_size == 2'b00);
   assign in_half = (req_size == 2'b01);
   assign in_word = req_size[1];
   assign idx_in  = 32'(req_addr[31:2]) & 32'(MEM_WORDS - 1);

`ifdef LSU_MISALIGN_TRAP_EN
   logic fault_q;
   logic misalign;
   assign off_in     = req_addr[1:0];
   assign misalign   = (in_half & req_addr[0])
                     | (in_word & (|req_addr[1:0]));
   assign resp_fault = fault_q & (state == RESP);
`else
   assign off_in     = in_byte ? req_addr[1:0]
                     : in_half ? {req_addr[1], 1'b0}
                     : 2'b00;
   assign resp_fault = 1'b0;
`endif

   // Lane shift shared by the store merge and load extraction
   assign sh   = {off_q, 3'b000};
   assign mask = (size_q == 2'b00) ? (32'h0000_00FF << sh)
                                   : (32'h0000_FFFF << sh);
   assign ins  = (size_q == 2'b00) ? (32'(wdata_q[7:0]) << sh)
                                   : (32'(wdata_q) << sh);
   assign merged = (memDataOut & ~mask) | (ins & mask);

   assign lb = 8'(memDataOut >> sh);
   assign lh = 16'(memDataOut >> sh);

   always_comb begin
      loaded = memDataOut;
      if (size_q == 2'b00)
         loaded = sgn_q ? {{24{lb[7]}}, lb} : {24'd0, lb};
      else if (size_q == 2'b01)
         loaded = sgn_q ? {{16{lh[15]}}, lh} : {16'd0, lh};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         wr_q       <= 1'b0;
         sgn_q      <= 1'b0;
         size_q     <= 2'b00;
         off_q      <= 2'b00;
         wdata_q    <= 16'd0;
         memAddress <= 32'd0;
         memDataIn  <= 32'd0;
         resp_rdata <= 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
         fault_q    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  wr_q       <= req_write;
                  sgn_q      <= req_signed;
                  size_q     <= req_size;
                  off_q      <= off_in;
                  wdata_q    <= req_wdata[15:0];
                  memAddress <= idx_in;
                  resp_rdata <= 32'd0;
                  cnt        <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
                  fault_q    <= misalign;
                  if (misalign)
                     state <= RESP;
                  else
`endif
                  if (req_write && in_word) begin
                     memDataIn <= req_wdata;
                     state     <= WR;
                  end else begin
                     state <= RD;
                  end
               end
            end
            RD: begin
               if (cnt == CNT_LAST) begin
                  if (wr_q) begin
                     memDataIn <= merged;
                     state     <= WR;
                  end else begin
                     resp_rdata <= loaded;
                     state      <= RESP;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WR:      state <= RESP;
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random
// traffic against a word-array reference model.
module tb_load_store_unit;

   localparam int MEM_WORDS = 4;
   localparam int RD_LAT    = 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic        memRead;
   logic        memWrite;
   logic [31:0] memAddress;
   logic [31:0] memDataIn;
   logic [31:0] memDataOut;

   logic [31:0] mem     [MEM_WORDS];
   logic [31:0] ref_mem [MEM_WORDS];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   load_store_unit #(.MEM_WORDS(MEM_WORDS), .RD_LAT(RD_LAT)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_fault (resp_fault),
      .memRead    (memRead),
      .memWrite   (memWrite),
      .memAddress (memAddress),
      .memDataIn  (memDataIn),
      .memDataOut (memDataOut)
   );

   // data_memory stand-in: combinational read, write on negedge
   assign memDataOut = mem[memAddress[1:0]];
   always @(negedge clk)
      if (memWrite) mem[memAddress[1:0]] = memDataIn;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic preload(input int i, input logic [31:0] v);
      mem[i]     = v;
      ref_mem[i] = v;
   endtask

   task automatic run_op(input logic w, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a,
                         input logic [31:0] d);
      int          idx, off, nb, lat, t, got_k, rd_n, wr_n, ovl;
      bit          mis;
      logic [31:0] old, nw, exp_rd, lanes, got_rd, got_flt;
      idx = int'((a >> 2) % MEM_WORDS);
      nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis = (a % nb) != 0;
`endif
      off = int'(a % 4);
      off = off - (off % nb);
      old = ref_mem[idx];
      nw  = old;
      exp_rd = 32'd0;
      lanes = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 1);
      if (w) begin
         nw = (old & ~(lanes << (8 * off))) | ((d & lanes) << (8 * off));
      end else begin
         exp_rd = (old >> (8 * off)) & lanes;
         if (sg && nb < 4 && exp_rd[8 * nb - 1])
            exp_rd = exp_rd | ~lanes;
      end
      if (mis) begin
         lat = 1;
         nw = old;
         exp_rd = 32'd0;
      end else if (w && nb == 4) lat = 2;
      else if (w) lat = RD_LAT + 2;
      else lat = RD_LAT + 1;

      t = 0;
      while (!req_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_write  = w;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = d;
      @(posedge clk);
      got_k = 0; rd_n = 0; wr_n = 0; ovl = 0;
      got_rd = 32'd0; got_flt = 32'd0;
      for (int k = 1; k <= lat + 3; k++) begin
         @(negedge clk);
         req_valid = 1'b0;
         req_addr  = $urandom;
         if (memRead && memWrite) ovl++;
         if (memRead) begin
            rd_n++;
            check("rd_addr", memAddress, 32'(idx));
         end
         if (memWrite) begin
            wr_n++;
            check("wr_addr", memAddress, 32'(idx));
            check("wr_data", memDataIn, nw);
         end
         if (resp_valid) begin
            if (got_k == 0) begin
               got_k   = k;
               got_rd  = resp_rdata;
               got_flt = 32'(resp_fault);
            end else got_k = -1;
         end
      end
      check("resp_cycle", 32'(got_k), 32'(lat));
      check("resp_rdata", got_rd, exp_rd);
      check("resp_fault", got_flt, 32'(mis));
      check("rd_cycles", 32'(rd_n),
            32'((mis || (w && nb == 4)) ? 0 : RD_LAT));
      check("wr_cycles", 32'(wr_n), 32'((w && !mis) ? 1 : 0));
      check("rd_wr_overlap", 32'(ovl), 32'd0);
      ref_mem[idx] = nw;
      check("mem_word", mem[idx], ref_mem[idx]);
   endtask

   initial begin
      int bad;
      for (int i = 0; i < MEM_WORDS; i++) preload(i, 32'd0);
      reset      = 1'b1;
      req_valid  = 1'b1;
      req_write  = 1'b0;
      req_size   = 2'b10;
      req_signed = 1'b0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;

      // 1: reset held with a request pending
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("rst_ready", 32'(req_ready), 32'd0);
         check("rst_strobes",
               {29'd0, memRead, memWrite, resp_valid}, 32'd0);
      end
      check("rst_outs", memAddress | memDataIn | resp_rdata, 32'd0);
      req_valid = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      check("rst_release_ready", 32'(req_ready), 32'd1);

      // 2: word store
      run_op(1'b1, 2'b10, 1'b0, 32'h4, 32'hDEAD_BEEF);
      check("t2_mem1", mem[1], 32'hDEAD_BEEF);

      // 3: sub-word loads
      preload(1, 32'h8899_AABB);
      run_op(1'b0, 2'b00, 1'b1, 32'h7, 32'h0);
      run_op(1'b0, 2'b00, 1'b0, 32'h7, 32'h0);
      run_op(1'b0, 2'b01, 1'b1, 32'h4, 32'h0);

      // 4: byte store merge
      preload(1, 32'hDEAD_BEEF);
      run_op(1'b1, 2'b00, 1'b0, 32'h5, 32'h0000_0055);
      check("t4_mem1", mem[1], 32'hDEAD_55EF);

      // 5: misaligned word load and address wrap
      run_op(1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
      preload(0, 32'h1234_5678);
      run_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

      // 6: reset during RD of a byte store
      preload(1, 32'hDEAD_BEEF);
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_size  = 2'b00;
      req_addr  = 32'h5;
      req_wdata = 32'h55;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("t6_in_rd", 32'(memRead), 32'd1);
      reset = 1'b1;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (memWrite || resp_valid || memRead) bad++;
      end
      check("t6_no_strobes", 32'(bad), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("t6_ready", 32'(req_ready), 32'd1);
      check("t6_mem1", mem[1], 32'hDEAD_BEEF);

      // random traffic
      for (int i = 0; i < 200; i++)
         run_op(1'($urandom), 2'($urandom), 1'($urandom),
                $urandom, $urandom);
      for (int i = 0; i < MEM_WORDS; i++)
         check("final_mem", mem[i], ref_mem[i]);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
